// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared register offsets, sequencer state encoding and the
//            step-to-access decode for the DMA channel programmer.
// Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

    localparam logic [3:0] c_reg_mask      = 4'd10;
    localparam logic [3:0] c_reg_mode      = 4'd11;
    localparam logic [3:0] c_reg_clear_ff  = 4'd12;
    localparam logic [3:0] c_step_last_prog = 4'd5;
    localparam logic [3:0] c_step_unmask   = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BUS = 3'd1,
        S_SETUP    = 3'd2,
        S_STROBE   = 3'd3,
        S_HOLD     = 3'd4,
        S_DONE     = 3'd5
    } dma_state_t;

    // For reads, data carries the byte the register is expected to return.
    typedef struct packed {
        logic [3:0] reg_addr;
        logic [7:0] data;
        logic       rd;
    } dma_access_t;

    // Channel registers occupy offsets 0..7: address at {0,ch,0}, count at {0,ch,1}.
    function automatic dma_access_t dma_access(
        input logic [3:0]  step,
        input logic [1:0]  ch,
        input logic [15:0] addr,
        input logic [15:0] count,
        input logic [5:0]  mode
    );
        dma_access_t a;
        logic [3:0]  addr_reg;
        logic [3:0]  cnt_reg;
        addr_reg = {1'b0, ch, 1'b0};
        cnt_reg  = {1'b0, ch, 1'b1};
        a = '{reg_addr: c_reg_mask, data: {6'b0, ch}, rd: 1'b0};
        case (step)
            4'd0, 4'd6: a = '{reg_addr: c_reg_clear_ff, data: 8'h00,        rd: 1'b0};
            4'd1:       a = '{reg_addr: addr_reg,       data: addr[7:0],    rd: 1'b0};
            4'd2:       a = '{reg_addr: addr_reg,       data: addr[15:8],   rd: 1'b0};
            4'd3:       a = '{reg_addr: cnt_reg,        data: count[7:0],   rd: 1'b0};
            4'd4:       a = '{reg_addr: cnt_reg,        data: count[15:8],  rd: 1'b0};
            4'd5:       a = '{reg_addr: c_reg_mode,     data: {mode, ch},   rd: 1'b0};
            4'd7:       a = '{reg_addr: addr_reg,       data: addr[7:0],    rd: 1'b1};
            4'd8:       a = '{reg_addr: addr_reg,       data: addr[15:8],   rd: 1'b1};
            4'd9:       a = '{reg_addr: cnt_reg,        data: count[7:0],   rd: 1'b1};
            4'd10:      a = '{reg_addr: cnt_reg,        data: count[15:8],  rd: 1'b1};
            default:    a = '{reg_addr: c_reg_mask,     data: {6'b0, ch},   rd: 1'b0};
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_channel_programmer_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_channel_programmer_if
// Purpose  : I/O bus between the channel programmer and the DMA register file.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_channel_programmer_if;
    logic [3:0] address_out;
    logic [7:0] data_out;
    logic       IOW;
    logic       IOR;
    logic       AEN;
    logic [7:0] data_in;

    modport master (output address_out, data_out, IOW, IOR, input AEN, data_in);
    modport slave  (input address_out, data_out, IOW, IOR, output AEN, data_in);
endinterface
`default_nettype wire

// File: rtl/dma_bus_cycle.sv
`default_nettype none
// ============================================================================
// Module   : dma_bus_cycle
// Purpose  : Drives one SETUP / STROBE / HOLD bus access and captures read data.
// Revision : 1.0 - initial release
// ============================================================================
module dma_bus_cycle
    import dma_pkg::*;
#(
    parameter int STROBE_CYCLES = 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire dma_state_t         i_state,
    input  wire dma_access_t        i_access,
    dma_channel_programmer_if.master bus,
    output logic                    o_strobe_last,
    output logic                    o_rd_valid,
    output logic [7:0]              o_rd_data
);

    logic [2:0] r_strobe_cnt;
    logic       r_rd_valid;
    logic [7:0] r_rd_data;
    logic       w_active;
    logic       w_strobe;

    assign w_active      = (i_state == S_SETUP) || (i_state == S_STROBE) || (i_state == S_HOLD);
    assign w_strobe      = (i_state == S_STROBE);
    assign o_strobe_last = w_strobe && (r_strobe_cnt == 3'(STROBE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe_cnt <= 3'd0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= 8'd0;
        end else begin
            if (w_strobe && !o_strobe_last) begin
                r_strobe_cnt <= r_strobe_cnt + 3'd1;
            end else begin
                r_strobe_cnt <= 3'd0;
            end
            r_rd_valid <= o_strobe_last && i_access.rd;
            if (o_strobe_last && i_access.rd) begin
                r_rd_data <= bus.data_in;
            end
        end
    end

    // Strobes decode straight from the state register so reset releases them at once.
    assign bus.address_out = w_active ? i_access.reg_addr : 4'd0;
    assign bus.data_out    = (w_active && !i_access.rd) ? i_access.data : 8'd0;
    assign bus.IOW         = !(w_strobe && !i_access.rd);
    assign bus.IOR         = !(w_strobe && i_access.rd);
    assign o_rd_valid      = r_rd_valid;
    assign o_rd_data       = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/dma_channel_programmer.sv
`default_nettype none
// ============================================================================
// Module   : dma_channel_programmer
// Purpose  : Sequences the register accesses that program and unmask one DMA channel.
// Revision : 1.0 - initial release
// ============================================================================
module dma_channel_programmer
    import dma_pkg::*;
#(
    parameter int STROBE_CYCLES  = 1,
    parameter bit VERIFY_DEFAULT = 1'b0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    input  wire logic [1:0]         ch_sel,
    input  wire logic [15:0]        prog_address,
    input  wire logic [15:0]        prog_count,
    input  wire logic [5:0]         prog_mode,
    input  wire logic               verify_en,
    dma_channel_programmer_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic                    verify_err
);

    dma_state_t  r_state;
    dma_state_t  w_state_next;
    logic [3:0]  r_step;
    logic [1:0]  r_ch;
    logic [15:0] r_addr;
    logic [15:0] r_count;
    logic [5:0]  r_mode;
    logic        r_verify;
    logic        r_verify_err;

    dma_access_t w_access;
    logic        w_accept;
    logic        w_last_step;
    logic [3:0]  w_step_next;
    logic        w_strobe_last;
    logic        w_rd_valid;
    logic [7:0]  w_rd_data;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_last_step = (r_step == c_step_unmask);
    // Without readback the sequence jumps from the mode write straight to the unmask.
    assign w_step_next = (r_step == c_step_last_prog && !r_verify) ? c_step_unmask : r_step + 4'd1;
    assign w_access    = dma_access(r_step, r_ch, r_addr, r_count, r_mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_next = bus.AEN ? S_WAIT_BUS : S_SETUP;
            S_WAIT_BUS: if (!bus.AEN) w_state_next = S_SETUP;
            S_SETUP:    w_state_next = S_STROBE;
            S_STROBE:   if (w_strobe_last) w_state_next = S_HOLD;
            S_HOLD: begin
                if (w_last_step)  w_state_next = S_DONE;
                else if (bus.AEN) w_state_next = S_WAIT_BUS;
                else              w_state_next = S_SETUP;
            end
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step       <= 4'd0;
            r_ch         <= 2'd0;
            r_addr       <= 16'd0;
            r_count      <= 16'd0;
            r_mode       <= 6'd0;
            r_verify     <= 1'b0;
            r_verify_err <= 1'b0;
        end else if (w_accept) begin
            r_step       <= 4'd0;
            r_ch         <= ch_sel;
            r_addr       <= prog_address;
            r_count      <= prog_count;
            r_mode       <= prog_mode;
            r_verify     <= verify_en | VERIFY_DEFAULT;
            r_verify_err <= 1'b0;
        end else begin
            if (r_state == S_HOLD && !w_last_step) begin
                r_step <= w_step_next;
            end else if (r_state == S_DONE) begin
                r_step <= 4'd0;
            end
            if (r_state == S_HOLD && w_rd_valid && (w_rd_data != w_access.data)) begin
                r_verify_err <= 1'b1;
            end
        end
    end

    dma_bus_cycle #(
        .STROBE_CYCLES (STROBE_CYCLES)
    ) u_bus_cycle (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_state       (r_state),
        .i_access      (w_access),
        .bus           (bus),
        .o_strobe_last (w_strobe_last),
        .o_rd_valid    (w_rd_valid),
        .o_rd_data     (w_rd_data)
    );

    assign busy       = (r_state == S_WAIT_BUS) || (r_state == S_SETUP) ||
                        (r_state == S_STROBE)   || (r_state == S_HOLD);
    assign done       = (r_state == S_DONE);
    assign verify_err = r_verify_err;

endmodule
`default_nettype wire

// File: tb/tb_dma_channel_programmer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_channel_programmer
// Purpose  : Directed bench with an 8237-style register file model behind the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_channel_programmer;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        logic       rd;
    } acc_t;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] addr;
        logic [15:0] count;
        logic [5:0]  mode;
        logic        verify;
        logic        corrupt;
        int          aen_on;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start1 = 1'b0, ver1 = 1'b0;
    logic [1:0]  ch1 = '0;
    logic [15:0] addr1 = '0, cnt1 = '0;
    logic [5:0]  mode1 = '0;
    logic        busy1, done1, verr1;

    logic        start3 = 1'b0;
    logic [1:0]  ch3 = '0;
    logic [15:0] addr3 = '0, cnt3 = '0;
    logic [5:0]  mode3 = '0;
    logic        busy3, done3, verr3;

    int n_cmp = 0;
    int n_fail = 0;

    // Register file model: byte flip-flop plus eight 16-bit channel registers.
    logic [15:0] m_reg [8];
    logic        ff = 1'b0;
    logic        corrupt = 1'b0;
    acc_t        cur1, cur3;
    acc_t        log1[$], log3[$], exp_q[$];
    int          lens3[$];
    int          low1 = 0, low3 = 0;
    int          both_low = 0, aen_viol = 0, ior3_low = 0;

    dma_channel_programmer_if b1 ();
    dma_channel_programmer_if b3 ();

    assign b1.data_in = (corrupt && !ff && b1.address_out < 4'd8 && !b1.address_out[0]) ? 8'h2D :
                        (ff ? m_reg[b1.address_out[2:0]][15:8] : m_reg[b1.address_out[2:0]][7:0]);
    assign b3.data_in = 8'h00;
    assign b3.AEN     = 1'b0;

    dma_channel_programmer #(.STROBE_CYCLES(1), .VERIFY_DEFAULT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .ch_sel(ch1), .prog_address(addr1),
        .prog_count(cnt1), .prog_mode(mode1), .verify_en(ver1), .bus(b1),
        .busy(busy1), .done(done1), .verify_err(verr1));

    dma_channel_programmer #(.STROBE_CYCLES(3), .VERIFY_DEFAULT(1'b0)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .ch_sel(ch3), .prog_address(addr3),
        .prog_count(cnt3), .prog_mode(mode3), .verify_en(1'b0), .bus(b3),
        .busy(busy3), .done(done3), .verify_err(verr3));

    always @(negedge clk) begin
        if (!b1.IOW && !b1.IOR) both_low++;
        if (!b1.IOW || !b1.IOR) begin
            if (low1 == 0) begin
                if (b1.AEN) aen_viol++;
                cur1 = '{addr: b1.address_out, data: (b1.IOR ? b1.data_out : b1.data_in), rd: !b1.IOR};
            end
            low1++;
        end else if (low1 != 0) begin
            log1.push_back(cur1);
            if (cur1.addr == 4'd12) begin
                ff = 1'b0;
            end else if (cur1.addr < 4'd8) begin
                if (!cur1.rd) begin
                    if (ff) m_reg[cur1.addr[2:0]][15:8] = cur1.data;
                    else    m_reg[cur1.addr[2:0]][7:0]  = cur1.data;
                end
                ff = !ff;
            end
            low1 = 0;
        end
    end

    always @(negedge clk) begin
        if (!b3.IOR) ior3_low++;
        if (!b3.IOW) begin
            if (low3 == 0) cur3 = '{addr: b3.address_out, data: b3.data_out, rd: 1'b0};
            low3++;
        end else if (low3 != 0) begin
            log3.push_back(cur3);
            lens3.push_back(low3);
            low3 = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void build_exp(input vec_t v);
        logic [3:0] ar;
        logic [3:0] cr;
        ar = {1'b0, v.ch, 1'b0};
        cr = {1'b0, v.ch, 1'b1};
        exp_q.delete();
        exp_q.push_back('{4'd12, 8'h00, 1'b0});
        exp_q.push_back('{ar, v.addr[7:0], 1'b0});
        exp_q.push_back('{ar, v.addr[15:8], 1'b0});
        exp_q.push_back('{cr, v.count[7:0], 1'b0});
        exp_q.push_back('{cr, v.count[15:8], 1'b0});
        exp_q.push_back('{4'd11, {v.mode, v.ch}, 1'b0});
        if (v.verify) begin
            exp_q.push_back('{4'd12, 8'h00, 1'b0});
            exp_q.push_back('{ar, (v.corrupt ? 8'h2D : v.addr[7:0]), 1'b1});
            exp_q.push_back('{ar, v.addr[15:8], 1'b1});
            exp_q.push_back('{cr, v.count[7:0], 1'b1});
            exp_q.push_back('{cr, v.count[15:8], 1'b1});
        end
        exp_q.push_back('{4'd10, {6'b0, v.ch}, 1'b0});
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        corrupt = v.corrupt;
        log1.delete();
        build_exp(v);
        @(negedge clk);
        ch1 = v.ch; addr1 = v.addr; cnt1 = v.count; mode1 = v.mode; ver1 = v.verify; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        // Scramble the inputs so only latched values can produce the right trace.
        ch1 = ~v.ch; addr1 = ~v.addr; cnt1 = ~v.count; mode1 = ~v.mode; ver1 = ~v.verify;
        cyc = 1;
        chk($sformatf("v%0d_busy_after_start", idx), busy1, 1);
        chk($sformatf("v%0d_verr_cleared", idx), verr1, 0);
        while (!done1 && cyc < 200) begin
            if (v.aen_on != 0 && cyc == v.aen_on)     b1.AEN = 1'b1;
            if (v.aen_on != 0 && cyc == v.aen_on + 5) b1.AEN = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        b1.AEN = 1'b0;
        chk($sformatf("v%0d_done_cycle", idx), cyc, v.exp_done);
        chk($sformatf("v%0d_busy_at_done", idx), busy1, 0);
        chk($sformatf("v%0d_verify_err", idx), verr1, v.exp_err);
        chk($sformatf("v%0d_n_access", idx), log1.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log1.size(); i++)
            chk($sformatf("v%0d_acc%0d", idx, i), log1[i], exp_q[i]);
        chk($sformatf("v%0d_model_addr", idx), m_reg[{v.ch, 1'b0}], v.addr);
        chk($sformatf("v%0d_model_count", idx), m_reg[{v.ch, 1'b1}], v.count);
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_pulse", idx), {done1, busy1, b1.IOW, b1.IOR}, 4'b0011);
        chk($sformatf("v%0d_idle_bus", idx), {b1.address_out, b1.data_out}, 12'h000);
    endtask

    vec_t vecs[6];

    initial begin
        int cyc;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        b1.AEN = 1'b0;
        vecs[0] = '{2'd1, 16'h012C, 16'h000A, 6'h12, 1'b0, 1'b0, 0, 22, 1'b0};
        vecs[1] = '{2'd1, 16'h012C, 16'h000A, 6'h12, 1'b1, 1'b0, 0, 37, 1'b0};
        vecs[2] = '{2'd2, 16'hBEEF, 16'h1234, 6'h3F, 1'b1, 1'b1, 0, 37, 1'b1};
        vecs[3] = '{2'd0, 16'hFFFF, 16'h0000, 6'h00, 1'b0, 1'b0, 0, 22, 1'b0};
        vecs[4] = '{2'd1, 16'h012C, 16'h000A, 6'h12, 1'b0, 1'b0, 6, 27, 1'b0};
        vecs[5] = '{2'd3, 16'hA55A, 16'h0100, 6'h15, 1'b1, 1'b0, 0, 37, 1'b0};

        #12;
        chk("reset_strobes", {b1.IOW, b1.IOR}, 2'b11);
        chk("reset_flags", {busy1, done1, verr1}, 3'b000);
        chk("reset_bus", {b1.address_out, b1.data_out}, 12'h000);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset while a write strobe is low, then reprogram channel 3.
        corrupt = 1'b0;
        @(negedge clk);
        ch1 = 2'd1; addr1 = 16'h012C; cnt1 = 16'h000A; mode1 = 6'h12; ver1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 0;
        while (b1.IOW && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_iow_seen_low", b1.IOW, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_strobes", {b1.IOW, b1.IOR}, 2'b11);
        chk("rst_async_flags", {busy1, done1, verr1}, 3'b000);
        chk("rst_async_bus", {b1.address_out, b1.data_out}, 12'h000);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_resume", {busy1, b1.IOW}, 2'b01);
        run_vec(vecs[5], 5);

        // Longer strobes; a second start mid-sequence must be ignored.
        log3.delete(); lens3.delete();
        @(negedge clk);
        ch3 = 2'd1; addr3 = 16'h012C; cnt3 = 16'h000A; mode3 = 6'h12; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        cyc = 1;
        while (!done3 && cyc < 300) begin
            if (cyc == 10) begin
                ch3 = 2'd2; addr3 = 16'h5555; cnt3 = 16'h7777; mode3 = 6'h01; start3 = 1'b1;
            end
            if (cyc == 11) start3 = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk("s3_done_cycle", cyc, 36);
        build_exp(vecs[0]);
        chk("s3_n_access", log3.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log3.size(); i++) begin
            chk($sformatf("s3_acc%0d", i), log3[i], exp_q[i]);
            chk($sformatf("s3_iow_len%0d", i), lens3[i], 3);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("s3_no_second_run", {busy3, done3}, 2'b00);

        chk("never_both_low", both_low, 0);
        chk("no_access_under_aen", aen_viol, 0);
        chk("s3_no_reads", ior3_low, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
